// File: rtl/segment_sequencer.sv
// Segment animator: reveals, chases or erases the lit segments of one character, one step per
// pacing tick period. Optional descending scan via the SEGSEQ_REVERSE_EN macro (adds input dir).
module segment_sequencer #(
  parameter int NUM_SEGS = 7,
  parameter int DELAY_W  = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                tick,
  input  logic                char_valid,
  output logic                char_ready,
  input  logic [NUM_SEGS-1:0] char_in,
  input  logic [1:0]          mode,
  input  logic [DELAY_W-1:0]  delay,
`ifdef SEGSEQ_REVERSE_EN
  input  logic                dir,
`endif
  output logic [NUM_SEGS-1:0] seg_out,
  output logic                busy,
  output logic                done
);

  localparam int                  IDX_W    = $clog2(NUM_SEGS + 1);
  localparam logic [IDX_W-1:0]    IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]    IDX_END  = IDX_W'(NUM_SEGS);
  localparam logic [NUM_SEGS-1:0] SEG_ONE  = NUM_SEGS'(1);
  localparam logic [DELAY_W-1:0]  DLY_ZERO = {DELAY_W{1'b0}};
  localparam logic [DELAY_W-1:0]  DLY_ONE  = DELAY_W'(1);

  localparam logic [1:0] MODE_FILL    = 2'b00;
  localparam logic [1:0] MODE_CHASE   = 2'b01;
  localparam logic [1:0] MODE_ERASE   = 2'b10;
  localparam logic [1:0] MODE_INSTANT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                state_r;
  logic [NUM_SEGS-1:0]   char_r;
  logic [1:0]            mode_r;
  logic [DELAY_W-1:0]    delay_r;
  logic [DELAY_W-1:0]    timer_r;
  logic [IDX_W-1:0]      idx_r;
  logic                  tick_prev_r;
`ifdef SEGSEQ_REVERSE_EN
  logic                  dir_r;
`endif

  logic                  accept_s;
  logic                  tick_edge_s;
  logic                  lit_s;
  logic [NUM_SEGS-1:0]   onehot_s;
  logic [IDX_W-1:0]      next_idx_s;
  logic [IDX_W-1:0]      start_idx_s;

  assign char_ready  = enable && (state_r != ST_SCAN);
  assign busy        = (state_r != ST_IDLE);
  assign accept_s    = char_valid && char_ready;
  assign tick_edge_s = tick && !tick_prev_r;
  // Shifting past the top bit yields zero, so the terminal index never reads as lit.
  assign onehot_s    = SEG_ONE << idx_r;
  assign lit_s       = |(char_r & onehot_s);

  // Scan order: first index at accept and successor of the current index.
  always_comb begin
    next_idx_s  = idx_r + IDX_W'(1);
    start_idx_s = IDX_ZERO;
`ifdef SEGSEQ_REVERSE_EN
    // Descending scan wraps from index 0 to the terminal index.
    if (dir_r) begin
      if (idx_r == IDX_ZERO) begin
        next_idx_s = IDX_END;
      end else begin
        next_idx_s = idx_r - IDX_W'(1);
      end
    end else begin
      next_idx_s = idx_r + IDX_W'(1);
    end
    if (dir) begin
      start_idx_s = IDX_W'(NUM_SEGS - 1);
    end else begin
      start_idx_s = IDX_ZERO;
    end
`endif
  end

  // Sequencer state, latched character and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      char_r      <= {NUM_SEGS{1'b0}};
      mode_r      <= MODE_FILL;
      delay_r     <= DLY_ZERO;
      timer_r     <= DLY_ZERO;
      idx_r       <= IDX_ZERO;
      tick_prev_r <= 1'b0;
      seg_out     <= {NUM_SEGS{1'b0}};
      done        <= 1'b0;
`ifdef SEGSEQ_REVERSE_EN
      dir_r       <= 1'b0;
`endif
    end else begin
      tick_prev_r <= tick;
      if (enable) begin
        done <= 1'b0;
        if (accept_s) begin
          char_r  <= char_in;
          mode_r  <= mode;
          delay_r <= delay;
          idx_r   <= start_idx_s;
`ifdef SEGSEQ_REVERSE_EN
          dir_r   <= dir;
`endif
          if (mode == MODE_INSTANT) begin
            seg_out <= char_in;
            state_r <= ST_DONE;
            done    <= 1'b1;
          end else begin
            seg_out <= (mode == MODE_ERASE) ? char_in : {NUM_SEGS{1'b0}};
            state_r <= ST_SCAN;
          end
        end else begin
          case (state_r)
            ST_IDLE: state_r <= ST_IDLE;
            ST_SCAN: begin
              if (idx_r == IDX_END) begin
                if (mode_r == MODE_CHASE) begin
                  seg_out <= {NUM_SEGS{1'b0}};
                end
                state_r <= ST_DONE;
                done    <= 1'b1;
              end else if (lit_s) begin
                case (mode_r)
                  MODE_FILL:  seg_out <= seg_out | onehot_s;
                  MODE_CHASE: seg_out <= onehot_s;
                  MODE_ERASE: seg_out <= seg_out & ~onehot_s;
                  default:    seg_out <= seg_out;
                endcase
                idx_r   <= next_idx_s;
                timer_r <= delay_r;
                state_r <= (delay_r == DLY_ZERO) ? ST_SCAN : ST_WAIT;
              end else begin
                idx_r <= next_idx_s;
              end
            end
            ST_WAIT: begin
              if (tick_edge_s) begin
                timer_r <= timer_r - DLY_ONE;
                if (timer_r == DLY_ONE) begin
                  state_r <= ST_SCAN;
                end
              end
            end
            ST_DONE: state_r <= ST_IDLE;
            default: state_r <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_segment_sequencer.sv
// Self-checking bench for segment_sequencer: an action-queue model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_segment_sequencer;

  localparam int NS = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          tick = 1'b0;
  logic          char_valid = 1'b0;
  logic          char_ready;
  logic [NS-1:0] char_in = '0;
  logic [1:0]    mode = 2'b00;
  logic [5:0]    delay = 6'd0;
  logic [NS-1:0] seg_out;
  logic          busy;
  logic          done;
`ifdef SEGSEQ_REVERSE_EN
  logic          dir = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  segment_sequencer #(.NUM_SEGS(NS), .DELAY_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick),
    .char_valid(char_valid), .char_ready(char_ready), .char_in(char_in),
    .mode(mode), .delay(delay),
`ifdef SEGSEQ_REVERSE_EN
    .dir(dir),
`endif
    .seg_out(seg_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Model: an accepted character becomes a queue of actions. A clock action takes one enabled
  // cycle and leaves the display at a known pattern; a tick action waits for N tick edges.
  typedef struct {
    bit            is_clk;
    bit            last;
    logic [NS-1:0] seg;
    int            ticks;
  } item_t;

  item_t         q[$];
  logic [NS-1:0] m_seg;
  bit            m_done;
  bit            in_done;
  bit            tprev;
  bit            tedge;
  bit            rev;

  function automatic void build(input logic [NS-1:0] ch, input logic [1:0] md,
                                input logic [5:0] dl, input bit rv);
    logic [NS-1:0] s;
    int            p;
    item_t         it;
    q.delete();
    s = (md == 2'b10) ? ch : '0;
    for (int k = 0; k < NS; k++) begin
      p = rv ? (NS - 1 - k) : k;
      if (ch[p]) begin
        case (md)
          2'b00:   s[p] = 1'b1;
          2'b01:   begin s = '0; s[p] = 1'b1; end
          2'b10:   s[p] = 1'b0;
          default: s = s;
        endcase
      end
      it.is_clk = 1'b1; it.last = 1'b0; it.seg = s; it.ticks = 0;
      q.push_back(it);
      if (ch[p] && dl != 6'd0) begin
        it.is_clk = 1'b0; it.ticks = int'(dl);
        q.push_back(it);
      end
    end
    if (md == 2'b01) s = '0;
    it.is_clk = 1'b1; it.last = 1'b1; it.seg = s; it.ticks = 0;
    q.push_back(it);
  endfunction

  function automatic bit m_scanning();
    return (q.size() > 0) && q[0].is_clk;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); m_seg = '0; m_done = 1'b0; in_done = 1'b0; tprev = 1'b0;
    end else begin
      tedge = tick && !tprev;
      tprev = tick;
      if (enable) begin
        m_done = 1'b0;
`ifdef SEGSEQ_REVERSE_EN
        rev = dir;
`else
        rev = 1'b0;
`endif
        if (char_valid && !m_scanning()) begin
          if (mode == 2'b11) begin
            q.delete(); m_seg = char_in; in_done = 1'b1; m_done = 1'b1;
          end else begin
            build(char_in, mode, delay, rev);
            m_seg = (mode == 2'b10) ? char_in : '0;
            in_done = 1'b0;
          end
        end else if (in_done) begin
          in_done = 1'b0;
        end else if (q.size() > 0) begin
          if (q[0].is_clk) begin
            m_seg = q[0].seg;
            if (q[0].last) begin in_done = 1'b1; m_done = 1'b1; end
            void'(q.pop_front());
          end else if (tedge) begin
            q[0].ticks = q[0].ticks - 1;
            if (q[0].ticks == 0) void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(posedge clk) begin
    #1;
    chk("seg_out", 32'(seg_out), 32'(m_seg));
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'((q.size() > 0) || in_done));
    chk("char_ready", 32'(char_ready), 32'(enable && !m_scanning()));
    if (done === 1'b1) done_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_pulse();
    tick = 1'b1; @(negedge clk);
    tick = 1'b0; @(negedge clk);
  endtask

  task automatic send(input logic [NS-1:0] ch, input logic [1:0] md, input logic [5:0] dl);
    int n = 0;
    while (!char_ready && n < 200) begin @(negedge clk); n++; end
    if (!char_ready) chk("send_ready_timeout", 32'(char_ready), 32'd1);
    char_in = ch; mode = md; delay = dl; char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick = ~tick; @(negedge clk); n++; end
    if (busy) chk("drain_timeout", 32'(busy), 32'd0);
    tick = 1'b0;
    cyc(2);
  endtask

  int d0;

  initial begin
    cyc(3);
    chk("rst_seg", 32'(seg_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1; enable = 1'b1;
    cyc(2);
    chk("rst_ready", 32'(char_ready), 32'd1);

    // FILL with delay 2
    d0 = done_cnt;
    send(7'b0000101, 2'b00, 6'd2);
    cyc(1);
    chk("t1_first", 32'(seg_out), 32'(7'b0000001));
    drain(200);
    chk("t1_final", 32'(seg_out), 32'(7'b0000101));
    chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

    // CHASE with delay 1
    d0 = done_cnt;
    send(7'b1000001, 2'b01, 6'd1);
    cyc(1);
    chk("t2_first", 32'(seg_out), 32'(7'b0000001));
    tick_pulse(); cyc(6);
    chk("t2_second", 32'(seg_out), 32'(7'b1000000));
    drain(200);
    chk("t2_final", 32'(seg_out), 32'd0);
    chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

    // ERASE with delay 0 needs no ticks
    d0 = done_cnt;
    send(7'b0000011, 2'b10, 6'd0);
    chk("t3_accept", 32'(seg_out), 32'(7'b0000011));
    cyc(1); chk("t3_step0", 32'(seg_out), 32'(7'b0000010));
    cyc(1); chk("t3_step1", 32'(seg_out), 32'(7'b0000000));
    cyc(10);
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Preempt a FILL in WAIT with INSTANT
    d0 = done_cnt;
    send(7'b1111111, 2'b00, 6'd5);
    cyc(1);
    repeat (5) tick_pulse();
    chk("t4_two_lit", 32'(seg_out), 32'(7'b0000011));
    send(7'b0110000, 2'b11, 6'd0);
    cyc(3);
    chk("t4_final", 32'(seg_out), 32'(7'b0110000));
    chk("t4_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Freeze in WAIT, then re-enable with tick already high
    send(7'b0000011, 2'b00, 6'd3);
    cyc(1); tick_pulse();
    enable = 1'b0;
    repeat (3) tick_pulse();
    chk("t5_frozen", 32'(seg_out), 32'(7'b0000001));
    tick = 1'b1; cyc(1);
    enable = 1'b1; cyc(3);
    tick = 1'b0; cyc(1);
    tick_pulse(); cyc(2);
    chk("t5_no_spurious", 32'(seg_out), 32'(7'b0000001));
    tick_pulse(); cyc(2);
    chk("t5_resumed", 32'(seg_out), 32'(7'b0000011));
    drain(200);

    // Asynchronous reset mid-WAIT
    send(7'b1111111, 2'b00, 6'd4);
    cyc(1); tick_pulse();
    rst_n = 1'b0; #1;
    chk("t6_seg", 32'(seg_out), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    @(negedge clk); rst_n = 1'b1; cyc(1);
    chk("t6_ready", 32'(char_ready), 32'd1);

`ifdef SEGSEQ_REVERSE_EN
    dir = 1'b1;
    send(7'b0000101, 2'b00, 6'd0);
    cyc(5);
    chk("rev_bit2_first", 32'(seg_out), 32'(7'b0000100));
    drain(200);
    chk("rev_final", 32'(seg_out), 32'(7'b0000101));
    dir = 1'b0;
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      enable     = ($urandom_range(0, 9) != 0);
      tick       = ($urandom_range(0, 2) == 0);
      char_valid = ($urandom_range(0, 5) == 0);
      char_in    = NS'($urandom);
      mode       = 2'($urandom);
      delay      = 6'($urandom_range(0, 3));
`ifdef SEGSEQ_REVERSE_EN
      dir        = 1'($urandom);
`endif
      if ($urandom_range(0, 699) == 0) begin
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      end
      @(negedge clk);
    end
    char_valid = 1'b0; enable = 1'b1;
    drain(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
